// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmitter: 8 data bits, LSB first, optional parity,
// 1 or 2 stop bits. Single-entry: one byte is accepted per frame, nothing is
// queued while a frame is in flight.
//
// Parameters
//   CLKS_PER_BIT  clocks per bit period (>= 2)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports
//   i_Clock      in   system clock
//   i_Reset_n    in   asynchronous, active-low reset
//   i_Tx_DV      in   byte valid; accepted on a rising edge where o_Tx_Ready = 1
//   i_Tx_Byte    in   byte to send; sampled only on the accept edge
//   o_Tx_Ready   out  high in IDLE only
//   o_Tx_Active  out  high from START through the last stop bit
//   o_Tx_Serial  out  serial line, idles high
//   o_Tx_Done    out  one-cycle pulse in the first IDLE cycle after a frame
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state,      state_d;
  logic [CNT_W-1:0] clk_cnt,    clk_cnt_d;
  logic [2:0]       bit_idx,    bit_idx_d;
  logic             stop_idx,   stop_idx_d;
  logic [7:0]       shift,      shift_d;
  logic             parity_bit, parity_bit_d;
  logic             tx_serial,  tx_serial_d;
  logic             tx_done,    tx_done_d;

  logic bit_end;
  assign bit_end = (clk_cnt == LAST_CNT);

  // NOTE: every register, including the data shift register, is cleared by the
  // asynchronous reset so the line goes high at once and no stale byte leaks
  // into the next frame.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= S_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tx_serial  <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed for this edge, independent of statement order.
      state      <= state_d;
      clk_cnt    <= clk_cnt_d;
      bit_idx    <= bit_idx_d;
      stop_idx   <= stop_idx_d;
      shift      <= shift_d;
      parity_bit <= parity_bit_d;
      tx_serial  <= tx_serial_d;
      tx_done    <= tx_done_d;
    end
  end

  // The serial line is registered from the next-state decision, so the level
  // of each bit appears in the same cycle the state enters that bit.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // forgets an assignment would otherwise infer a latch.
    state_d      = state;
    clk_cnt_d    = bit_end ? '0 : clk_cnt + CNT_W'(1);
    bit_idx_d    = bit_idx;
    stop_idx_d   = stop_idx;
    shift_d      = shift;
    parity_bit_d = parity_bit;
    tx_serial_d  = tx_serial;
    tx_done_d    = 1'b0;

    unique case (state)
      S_IDLE: begin
        clk_cnt_d   = '0;
        tx_serial_d = 1'b1;
        if (i_Tx_DV) begin
          state_d      = S_START;
          shift_d      = i_Tx_Byte;
          parity_bit_d = (PARITY == 1) ? ~^i_Tx_Byte : ^i_Tx_Byte;
          tx_serial_d  = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d     = S_DATA;
          bit_idx_d   = '0;
          tx_serial_d = shift[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            stop_idx_d = 1'b0;
            if (PARITY != 0) begin
              state_d     = S_PARITY;
              tx_serial_d = parity_bit;
            end else begin
              state_d     = S_STOP;
              tx_serial_d = 1'b1;
            end
          end else begin
            bit_idx_d   = bit_idx + 3'd1;
            shift_d     = {1'b0, shift[7:1]};
            tx_serial_d = shift[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d     = S_STOP;
          stop_idx_d  = 1'b0;
          tx_serial_d = 1'b1;
        end
      end

      S_STOP: begin
        tx_serial_d = 1'b1;
        if (bit_end) begin
          if (stop_idx == LAST_STOP) begin
            state_d   = S_IDLE;
            tx_done_d = 1'b1;
          end else begin
            stop_idx_d = stop_idx + 1'b1;
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        tx_serial_d = 1'b1;
      end
    endcase
  end

  assign o_Tx_Active = (state != S_IDLE);
  assign o_Tx_Ready  = ~o_Tx_Active;
  assign o_Tx_Serial = tx_serial;
  assign o_Tx_Done   = tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- directed bench for uart_tx at CLKS_PER_BIT = 4.
//   u0: no parity, 1 stop bit   u1: even parity, 2 stop bits
//   u2: odd parity, 1 stop bit
// Outputs are sampled on the falling clock edge; inputs change on the falling
// edge or shortly after the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       dv      [3];
  logic [7:0] byte_in [3];
  logic       ready   [3];
  logic       active  [3];
  logic       serial  [3];
  logic       done    [3];

  int n_cmp = 0;
  int n_err = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(byte_in[0]),
    .o_Tx_Ready(ready[0]), .o_Tx_Active(active[0]), .o_Tx_Serial(serial[0]),
    .o_Tx_Done(done[0]));

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u1 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(byte_in[1]),
    .o_Tx_Ready(ready[1]), .o_Tx_Active(active[1]), .o_Tx_Serial(serial[1]),
    .o_Tx_Done(done[1]));

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u2 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(byte_in[2]),
    .o_Tx_Ready(ready[2]), .o_Tx_Active(active[2]), .o_Tx_Serial(serial[2]),
    .o_Tx_Done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame bits in line order (index 0 = start bit); n_bits returns the length.
  task automatic make_frame(input logic [7:0] b, input int has_par, input logic par_bit,
                            input int stops, output logic [15:0] bits, output int n_bits);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    n_bits = 9;
    if (has_par != 0) begin
      bits[9] = par_bit;
      n_bits  = 10;
    end
    n_bits += stops;
  endtask

  // Each frame bit repeated CPB times, one entry per clock cycle.
  function automatic logic [63:0] expand(input logic [15:0] bits, input int n_bits);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n_bits * CPB; i++) r[i] = bits[i / CPB];
    return r;
  endfunction

  // Send one byte on unit u and check every bit period, the busy flags, the
  // Done pulse position and the idle line afterwards. When pulse_ff is set a
  // 0xFF request is injected mid-frame and must be ignored.
  task automatic run_frame(input int u, input logic [7:0] b, input int has_par,
                           input logic par_bit, input int stops, input string tag,
                           input logic pulse_ff);
    logic [15:0] bits;
    int          n_bits;
    logic [3:0]  obs;
    int          busy_bad;
    int          idle_bad;
    make_frame(b, has_par, par_bit, stops, bits, n_bits);
    @(negedge clk);
    check({tag, "_ready_before"}, 64'(ready[u]), 64'd1);
    dv[u]      = 1'b1;
    byte_in[u] = b;
    @(posedge clk);
    #1;
    dv[u]      = 1'b0;
    byte_in[u] = ~b;
    busy_bad   = 0;
    for (int i = 0; i < n_bits; i++) begin
      obs = '0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        obs[c] = serial[u];
        if (!(active[u] === 1'b1 && ready[u] === 1'b0 && done[u] === 1'b0)) busy_bad++;
        if (pulse_ff && i == 4) begin
          dv[u]      = (c == 0);
          byte_in[u] = 8'hFF;
        end
      end
      check($sformatf("%s_bit%0d", tag, i), 64'(obs), {64{bits[i]}} & 64'hF);
    end
    check({tag, "_busy_flags"}, 64'(busy_bad), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {61'd0, done[u], ready[u], serial[u]}, 64'b111);
    idle_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (!(done[u] === 1'b0 && serial[u] === 1'b1 && ready[u] === 1'b1)) idle_bad++;
    end
    check({tag, "_idle_after"}, 64'(idle_bad), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic        line  [0:99];
    logic [15:0] bits;
    int          n_bits;
    logic [63:0] obs1, obs2;
    int          done_cnt, done_pos1, done_pos2, bad;

    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      dv[u]      = 1'b0;
      byte_in[u] = 8'h00;
    end
    #12;
    for (int u = 0; u < 3; u++)
      check($sformatf("reset_u%0d", u),
            {60'd0, serial[u], ready[u], active[u], done[u]}, 64'b1100);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame, no parity: 0,1,0,1,0,1,0,1,0,1 with Done 41 cycles later.
    run_frame(0, 8'h55, 0, 1'b0, 1, "t1_55", 1'b0);

    // Parity variants: 0x07 has three ones; 0xA5 has four.
    run_frame(1, 8'h07, 1, 1'b1, 2, "t2_even07", 1'b0);
    run_frame(2, 8'h07, 1, 1'b0, 1, "t2_odd07", 1'b0);
    run_frame(1, 8'hA5, 1, 1'b0, 2, "t2_evenA5", 1'b0);
    run_frame(2, 8'hA5, 1, 1'b1, 1, "t2_oddA5", 1'b0);

    // Back-to-back with DV held high: second byte taken in the Done cycle.
    @(negedge clk);
    dv[0]      = 1'b1;
    byte_in[0] = 8'hA5;
    @(posedge clk);
    #1;
    byte_in[0] = 8'h3C;
    done_cnt = 0; done_pos1 = 0; done_pos2 = 0;
    for (int n = 1; n < 100; n++) begin
      @(negedge clk);
      line[n] = serial[0];
      if (done[0] === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) done_pos1 = n;
        if (done_cnt == 2) done_pos2 = n;
      end
      if (n == 42) begin
        dv[0]      = 1'b0;
        byte_in[0] = 8'h00;
      end
    end
    obs1 = '0;
    obs2 = '0;
    for (int i = 0; i < 40; i++) begin
      obs1[i] = line[1 + i];
      obs2[i] = line[42 + i];
    end
    make_frame(8'hA5, 0, 1'b0, 1, bits, n_bits);
    check("t3_frameA5", obs1, expand(bits, n_bits));
    make_frame(8'h3C, 0, 1'b0, 1, bits, n_bits);
    check("t3_frame3C", obs2, expand(bits, n_bits));
    check("t3_gap_high", 64'(line[41]), 64'd1);
    check("t3_done_count", 64'(done_cnt), 64'd2);
    check("t3_done_pos1", 64'(done_pos1), 64'd41);
    check("t3_done_pos2", 64'(done_pos2), 64'd82);
    bad = 0;
    for (int n = 82; n < 100; n++) if (line[n] !== 1'b1) bad++;
    check("t3_tail_high", 64'(bad), 64'd0);

    // Request while busy is dropped; the 0x00 frame stays intact.
    run_frame(0, 8'h00, 0, 1'b0, 1, "t4_busy00", 1'b1);

    // Reset during DATA of 0x81: line high at once, no Done.
    @(negedge clk);
    dv[0]      = 1'b1;
    byte_in[0] = 8'h81;
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_mid_data_low", 64'(serial[0]), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_reset_async",
          {60'd0, serial[0], ready[0], active[0], done[0]}, 64'b1100);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || serial[0] !== 1'b1) bad++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done[0] !== 1'b0 || serial[0] !== 1'b1 || ready[0] !== 1'b1) bad++;
    end
    check("t5_no_done_after_reset", 64'(bad), 64'd0);
    run_frame(0, 8'h42, 0, 1'b0, 1, "t5_after42", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
